// File: rtl/key_expander_inv.sv
// AES-128 inverse key expansion: starting from the round-10 key, presents round keys
// 10 down to 0, one per EMIT cycle, using four registered S-box lanes for SubWord.

module sBox_8 (
    input  logic       clk,
    input  logic       enc_dec,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    always_ff @(posedge clk) begin
        data_out <= enc_dec ? fwd_affine(gf_inv(data_in)) : gf_inv(inv_affine(data_in));
    end
endmodule

module key_expander_inv (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, EMIT, CALC, DONE} state_t;

    state_t       state;
    state_t       state_next;
    logic [127:0] key_reg;
    logic [3:0]   round;
    logic [7:0]   rcon;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p3;
    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;
    logic [127:0] prev_key;

    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        logic [8:0] t;
        t = x[0] ? ({1'b0, x} ^ 9'h11b) : {1'b0, x};
        return t[8:1];
    endfunction

    assign w0 = key_reg[127:96];
    assign w1 = key_reg[95:64];
    assign w2 = key_reg[63:32];
    assign w3 = key_reg[31:0];
    assign p3 = w3 ^ w2;

    // The S-box lanes register every edge; CALC consumes what was captured at the end of EMIT.
    assign sbox_in  = {p3[23:0], p3[31:24]};
    assign prev_key = {w0 ^ sbox_out ^ {rcon, 24'h0}, w1 ^ w0, w2 ^ w1, p3};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        sBox_8 u_sbox (
            .clk      (clk),
            .enc_dec  (1'b1),
            .data_in  (sbox_in[8*i +: 8]),
            .data_out (sbox_out[8*i +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            key_reg <= 128'h0;
            round   <= 4'd0;
            rcon    <= 8'h00;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_reg <= key_in;
                        round   <= 4'd10;
                        rcon    <= 8'h36;
                    end
                end
                CALC: begin
                    key_reg <= prev_key;
                    round   <= round - 4'd1;
                    rcon    <= inv_xtime(rcon);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        rk_valid   = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = EMIT;
            end
            EMIT: begin
                rk_valid   = 1'b1;
                state_next = (round == 4'd0) ? DONE : CALC;
            end
            CALC: state_next = EMIT;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // key_reg and round only change when leaving IDLE or CALC, so they hold outside EMIT.
    assign rk_out   = key_reg;
    assign rk_round = round;
endmodule

// File: tb/tb_key_expander_inv.sv
// Self-checking bench for key_expander_inv using FIPS-197 round keys and the zero-key schedule.

module tb_key_expander_inv;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         busy;
    logic         done;

    typedef struct {
        logic [127:0] key;
        int           round;
        logic [127:0] expect_rk;
    } vec_t;

    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int           n_checks = 0;
    int           n_fail = 0;
    int           strobes;
    logic [127:0] got [0:10];
    logic [127:0] fips_rk [0:10];
    vec_t         vecs [0:12];
    logic [127:0] last_key;

    key_expander_inv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; start is sampled at the next rising edge (T0).
    // Walks cycles T0+1..T0+22 and returns positioned at the falling edge of the DONE cycle.
    task automatic apply_stimulus(input logic [127:0] key, input bit hold);
        int exp_round;
        start   = 1'b1;
        key_in  = key;
        strobes = 0;
        for (int r = 0; r <= 10; r++) got[r] = 'x;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            start  = hold;
            key_in = ~key_in;
            check_output($sformatf("busy_c%0d", k), 128'(busy), 128'(1'b1));
            check_output($sformatf("done_c%0d", k), 128'(done), 128'(k == 22));
            check_output($sformatf("valid_c%0d", k), 128'(rk_valid), 128'((k % 2) == 1));
            if (rk_valid) strobes++;
            if ((k % 2) == 1) begin
                exp_round = 10 - (k - 1) / 2;
                check_output($sformatf("round_c%0d", k), 128'(rk_round), 128'(exp_round));
                got[exp_round] = rk_out;
            end
        end
        check_output("strobe_count", 128'(strobes), 128'(11));
    endtask

    task automatic check_fips_keys(input string tag);
        for (int r = 0; r <= 10; r++)
            check_output($sformatf("%s_rk%0d", tag, r), got[r], fips_rk[r]);
    endtask

    initial begin
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = FIPS_K10;
        for (int r = 0; r <= 10; r++) begin
            vecs[r].key       = FIPS_K10;
            vecs[r].round     = r;
            vecs[r].expect_rk = fips_rk[r];
        end
        vecs[11].key = ZERO_K10; vecs[11].round = 0;  vecs[11].expect_rk = 128'h0;
        vecs[12].key = ZERO_K10; vecs[12].round = 10; vecs[12].expect_rk = ZERO_K10;

        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = 128'h0;
        repeat (2) @(negedge clk);
        check_output("rst_rk_out", rk_out, 128'h0);
        check_output("rst_rk_round", 128'(rk_round), 128'h0);
        check_output("rst_rk_valid", 128'(rk_valid), 128'h0);
        check_output("rst_busy", 128'(busy), 128'h0);
        check_output("rst_done", 128'(done), 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of expected round keys; a new sequence is run whenever the key changes.
        last_key = 'x;
        for (int i = 0; i <= 12; i++) begin
            if (vecs[i].key !== last_key) begin
                apply_stimulus(vecs[i].key, 1'b0);
                @(negedge clk);
                check_output("idle_after_seq", 128'(busy), 128'h0);
                last_key = vecs[i].key;
            end
            check_output($sformatf("vec%0d_rk%0d", i, vecs[i].round), got[vecs[i].round], vecs[i].expect_rk);
        end

        // start pulsed during DONE is ignored
        apply_stimulus(FIPS_K10, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("done_pulse_idle_busy", 128'(busy), 128'h0);
        check_output("done_pulse_idle_valid", 128'(rk_valid), 128'h0);
        @(negedge clk);
        check_output("done_pulse_ignored", 128'(busy), 128'h0);

        // start held high for the whole sequence; only re-accepted once back in IDLE
        apply_stimulus(FIPS_K10, 1'b1);
        check_fips_keys("hold");
        @(negedge clk);
        key_in = FIPS_K10;
        check_output("hold_idle_busy", 128'(busy), 128'h0);
        check_output("hold_idle_done", 128'(done), 128'h0);
        @(negedge clk);
        start = 1'b0;
        check_output("hold_restart_busy", 128'(busy), 128'h1);
        check_output("hold_restart_valid", 128'(rk_valid), 128'h1);
        check_output("hold_restart_round", 128'(rk_round), 128'd10);
        check_output("hold_restart_key", rk_out, FIPS_K10);

        // reset during the CALC that follows round 6
        repeat (9) @(negedge clk);
        check_output("pre_rst_round", 128'(rk_round), 128'd6);
        check_output("pre_rst_valid", 128'(rk_valid), 128'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_output("mid_rst_rk_out", rk_out, 128'h0);
        check_output("mid_rst_rk_round", 128'(rk_round), 128'h0);
        check_output("mid_rst_valid", 128'(rk_valid), 128'h0);
        check_output("mid_rst_busy", 128'(busy), 128'h0);
        check_output("mid_rst_done", 128'(done), 128'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_output($sformatf("post_rst_done_%0d", c), 128'(done), 128'h0);
            check_output($sformatf("post_rst_busy_%0d", c), 128'(busy), 128'h0);
        end
        apply_stimulus(FIPS_K10, 1'b0);
        check_fips_keys("after_rst");

        // back-to-back: start in the first IDLE cycle after done
        @(negedge clk);
        apply_stimulus(FIPS_K10, 1'b0);
        check_fips_keys("b2b");
        @(negedge clk);
        check_output("b2b_final_idle", 128'(busy), 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
